uart_pkt_rx: RTL and testbench

UART_PKT_RX -- requirements
Module: uart_pkt_rx

---
 rtl/uart_pkt_rx_pkg.sv | 20 ++
 rtl/uart_byte_rx.sv | 134 +++++++++++++
 rtl/uart_pkt_rx.sv | 102 ++++++++++
 tb/tb_uart_pkt_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_rx_pkg.sv
// Shared definitions for the UART package receiver: FSM states and frame constants.
`timescale 1ns/1ps
package uart_pkt_rx_pkg;

    // Byte receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 50 MHz system clock / 19200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 2604;

    // Serial frame layout: 8 data bits, 1 stop bit
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_byte_rx.sv
// Byte-level UART receiver: input synchronizer, start/data/stop FSM, bit timer
// and LSB-first shift register. Reports each finished frame as a good byte or a
// framing error.
`timescale 1ns/1ps
module uart_byte_rx
    import uart_pkt_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic       line_idle,
    output logic       start_det
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    rx_state_t       state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_next;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_next;
    logic            wait_high;
    logic            wait_high_next;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // FSM state, bit timer, bit counter, shift register and post-error line guard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            wait_high <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            wait_high <= wait_high_next;
        end
    end

    // Next-state logic; a framing error leaves the line low, so a start is only accepted once it has gone high again
    always_comb begin
        state_next     = state;
        timer_next     = timer;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift_reg;
        wait_high_next = wait_high;
        byte_valid     = 1'b0;
        byte_ferr      = 1'b0;
        start_det      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_sync) begin
                    wait_high_next = 1'b0;
                end else if (!wait_high) begin
                    start_det  = 1'b1;
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (timer == HALF_M1) begin
                    timer_next = '0;
                    if (!rx_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == FULL_M1) begin
                    timer_next   = '0;
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            STOP: begin
                if (timer == FULL_M1) begin
                    timer_next = '0;
                    state_next = IDLE;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_ferr      = 1'b1;
                        wait_high_next = 1'b1;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_out  = shift_reg;
    assign line_idle = (state == IDLE);

endmodule

// File: rtl/uart_pkt_rx.sv
// UART package receiver: collects BYTES_PER_PKT bytes from uart_byte_rx into a
// package word, drops partial packages on framing error or inter-byte timeout.
`timescale 1ns/1ps
module uart_pkt_rx
    import uart_pkt_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int BYTES_PER_PKT = 8,
    parameter int TIMEOUT_CLKS  = 20 * CLKS_PER_BIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_in,
    output logic [8*BYTES_PER_PKT-1:0] data_out,
    output logic                       pkt_valid,
    output logic                       frame_err,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [2:0]    LAST_IDX = 3'(BYTES_PER_PKT - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT_CLKS);

    logic [7:0]                 byte_data;
    logic                       byte_valid;
    logic                       byte_ferr;
    logic                       line_idle;
    logic                       start_det;
    logic [2:0]                 byte_idx;
    logic [8*BYTES_PER_PKT-1:0] asm_reg;
    logic                       pkt_done;
    logic [GW-1:0]              gap_cnt;
    logic                       gap_run;
    logic                       gap_hit;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .byte_out  (byte_data),
        .byte_valid(byte_valid),
        .byte_ferr (byte_ferr),
        .line_idle (line_idle),
        .start_det (start_det)
    );

    assign gap_run = line_idle && (byte_idx != 3'd0) && !start_det;
    assign gap_hit = gap_run && (gap_cnt == GAP_MAX);

    // Inter-byte gap counter: only counts while a partial package waits for its next start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (!gap_run || gap_hit) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // Package assembly; the last lane is published one cycle after it is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx    <= '0;
            asm_reg     <= '0;
            pkt_done    <= 1'b0;
            data_out    <= '0;
            pkt_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pkt_valid   <= 1'b0;
            timeout_err <= 1'b0;
            pkt_done    <= 1'b0;
            frame_err   <= byte_ferr;
            if (pkt_done) begin
                data_out  <= asm_reg;
                pkt_valid <= 1'b1;
                byte_idx  <= '0;
            end else if (byte_ferr) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                for (int k = 0; k < BYTES_PER_PKT; k++) begin
                    if (byte_idx == 3'(k)) begin
                        asm_reg[8*k +: 8] <= byte_data;
                    end
                end
                byte_idx <= byte_idx + 3'd1;
                pkt_done <= (byte_idx == LAST_IDX);
            end else if (gap_hit) begin
                byte_idx    <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

    assign busy = !line_idle || (byte_idx != 3'd0);

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Testbench for uart_pkt_rx: table of whole packages at nominal and +/-3% bit
// rates, plus hand sequences for glitch, framing error, timeout and mid-package reset.
`timescale 1ns/1ps
module tb_uart_pkt_rx;

    localparam int CPB = 16;
    localparam int NB  = 8;
    localparam int TO  = 320;
    localparam realtime BIT_NOM  = 160.0;
    localparam realtime BIT_FAST = 155.2;
    localparam realtime BIT_SLOW = 164.8;

    typedef logic [7:0] byte_arr_t [8];

    typedef struct {
        string       name;
        byte_arr_t   bytes;
        realtime     bit_ns;
        logic [63:0] expect_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rx_in;
    logic [63:0] data_out;
    logic        pkt_valid;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;

    int errors      = 0;
    int checks      = 0;
    int pv_cnt      = 0;
    int fe_cnt      = 0;
    int to_cnt      = 0;
    int overlap_cnt = 0;
    int pv0, fe0, to0;

    vec_t vecs [6];

    uart_pkt_rx #(
        .CLKS_PER_BIT (CPB),
        .BYTES_PER_PKT(NB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    // 100 MHz bench clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count output pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (pkt_valid)   pv_cnt = pv_cnt + 1;
        if (frame_err)   fe_cnt = fe_cnt + 1;
        if (timeout_err) to_cnt = to_cnt + 1;
        if ((int'(pkt_valid) + int'(frame_err) + int'(timeout_err)) > 1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic snapshot();
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        to0 = to_cnt;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop_bit, input realtime bit_t);
        rx_in = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            #(bit_t);
        end
        rx_in = stop_bit;
        #(bit_t);
        rx_in = 1'b1;
    endtask

    task automatic sendBytes(input byte_arr_t b, input int first, input int n, input realtime bit_t);
        @(negedge clk);
        for (int k = first; k < first + n; k++) begin
            sendByte(b[k], 1'b1, bit_t);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        snapshot();
        sendBytes(v.bytes, 0, 8, v.bit_ns);
        repeat (20) @(negedge clk);
        checkOutput({v.name, " pkt_valid count"},   64'(pv_cnt - pv0), 64'd1);
        checkOutput({v.name, " frame_err count"},   64'(fe_cnt - fe0), 64'd0);
        checkOutput({v.name, " timeout_err count"}, 64'(to_cnt - to0), 64'd0);
        checkOutput({v.name, " data_out"},          data_out,          v.expect_data);
        checkOutput({v.name, " busy after"},        64'(busy),         64'd0);
    endtask

    initial begin
        byte_arr_t b;

        vecs[0] = '{"basic", '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}, BIT_NOM,  64'h0123_4567_89AB_CDEF};
        vecs[1] = '{"zeros", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, BIT_NOM,  64'h0000_0000_0000_0000};
        vecs[2] = '{"ones",  '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, BIT_NOM,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{"alt",   '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h3C, 8'hC3}, BIT_NOM,  64'hC33C_7E81_F00F_AA55};
        vecs[4] = '{"fast3", '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE}, BIT_FAST, 64'hFEDC_BA98_7654_3210};
        vecs[5] = '{"slow3", '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h96, 8'h69, 8'hE1, 8'h1E}, BIT_SLOW, 64'h1EE1_6996_3CC3_A55A};

        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset data_out",    data_out,           64'd0);
        checkOutput("reset pkt_valid",   64'(pkt_valid),     64'd0);
        checkOutput("reset frame_err",   64'(frame_err),     64'd0);
        checkOutput("reset timeout_err", 64'(timeout_err),   64'd0);
        checkOutput("reset busy",        64'(busy),          64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Short low glitch must be rejected silently
        snapshot();
        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch busy",       64'(busy),          64'd0);
        checkOutput("glitch frame_err",  64'(fe_cnt - fe0),  64'd0);
        checkOutput("glitch data_out",   data_out,           64'h1EE1_6996_3CC3_A55A);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        sendBytes(b, 0, 8, BIT_NOM);
        repeat (20) @(negedge clk);
        checkOutput("glitch pkt_valid",  64'(pv_cnt - pv0),  64'd1);
        checkOutput("glitch timeout",    64'(to_cnt - to0),  64'd0);
        checkOutput("glitch pkt data",   data_out,           64'h8877_6655_4433_2211);

        // Framing error mid-package discards the partial bytes
        snapshot();
        b = '{8'hDE, 8'hAD, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendBytes(b, 0, 3, BIT_NOM);
        sendByte(8'hEF, 1'b0, BIT_NOM);
        #(2.0 * BIT_NOM);
        repeat (5) @(negedge clk);
        checkOutput("ferr count",        64'(fe_cnt - fe0),  64'd1);
        checkOutput("ferr busy",         64'(busy),          64'd0);
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        sendBytes(b, 0, 7, BIT_NOM);
        repeat (5) @(negedge clk);
        checkOutput("ferr data held",    data_out,           64'h8877_6655_4433_2211);
        checkOutput("ferr no early pkt", 64'(pv_cnt - pv0),  64'd0);
        sendBytes(b, 7, 1, BIT_NOM);
        repeat (20) @(negedge clk);
        checkOutput("ferr pkt_valid",    64'(pv_cnt - pv0),  64'd1);
        checkOutput("ferr pkt data",     data_out,           64'h0807_0605_0403_0201);
        checkOutput("ferr single pulse", 64'(fe_cnt - fe0),  64'd1);

        // Inter-byte timeout drops a 5-byte partial package
        snapshot();
        b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'h00};
        sendBytes(b, 0, 5, BIT_NOM);
        repeat (300) @(negedge clk);
        checkOutput("timeout not early", 64'(to_cnt - to0),  64'd0);
        checkOutput("timeout busy wait", 64'(busy),          64'd1);
        repeat (100) @(negedge clk);
        checkOutput("timeout count",     64'(to_cnt - to0),  64'd1);
        checkOutput("timeout busy",      64'(busy),          64'd0);
        checkOutput("timeout data held", data_out,           64'h0807_0605_0403_0201);
        b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        sendBytes(b, 0, 8, BIT_NOM);
        repeat (20) @(negedge clk);
        checkOutput("timeout pkt_valid", 64'(pv_cnt - pv0),  64'd1);
        checkOutput("timeout pkt data",  data_out,           64'hB7B6_B5B4_B3B2_B1B0);
        checkOutput("timeout ferr",      64'(fe_cnt - fe0),  64'd0);

        // Reset during the 4th byte clears everything
        snapshot();
        b = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendBytes(b, 0, 3, BIT_NOM);
        rx_in = 1'b0;
        #(BIT_NOM);
        rx_in = 1'b1;
        #(BIT_NOM);
        rx_in = 1'b0;
        #(BIT_NOM);
        rx_in = 1'b1;
        #(BIT_NOM);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst data_out",      data_out,           64'd0);
        checkOutput("rst busy",          64'(busy),          64'd0);
        rx_in = 1'b1;
        rst   = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("rst idle busy",     64'(busy),          64'd0);
        b = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
        sendBytes(b, 0, 7, BIT_NOM);
        repeat (5) @(negedge clk);
        checkOutput("rst data still 0",  data_out,           64'd0);
        sendBytes(b, 7, 1, BIT_NOM);
        repeat (20) @(negedge clk);
        checkOutput("rst pkt_valid",     64'(pv_cnt - pv0),  64'd1);
        checkOutput("rst pkt data",      data_out,           64'hD7D6_D5D4_D3D2_D1D0);
        checkOutput("rst no errors",     64'(fe_cnt - fe0 + to_cnt - to0), 64'd0);

        checkOutput("pulse overlap",     64'(overlap_cnt),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
